// File: rtl/dzcpu_useq.sv
// Micro-sequencer for the dzcpu core: fetches an opcode byte, dispatches through
// the main or CB flow LUT, then steps the micro-PC through ucode ROM until a flow ends.
module dzcpu_useq #(
    parameter int         P_FLOW_W = 3,
    parameter logic [4:0] P_JCB    = 5'h0A
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iMopValid,
    input  logic [7:0]  iMemData,
    input  logic [7:0]  iFlowIdx,
    input  logic [7:0]  iCbFlowIdx,
    input  logic [11:0] iUop,
    input  logic        iZeroFlag,
    input  logic        iStall,
    output logic [7:0]  oMop,
    output logic [7:0]  oUAddr,
    output logic        oUopValid,
    output logic [4:0]  oUopOp,
    output logic [3:0]  oUopArg,
    output logic        oIncPc,
    output logic        oFetchReq,
    output logic        oRetire,
    output logic [2:0]  oState
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FETCH       = 3'd1,
        S_DISPATCH    = 3'd2,
        S_DISPATCH_CB = 3'd3,
        S_EXEC        = 3'd4
    } state_t;

    state_t                state;
    logic [7:0]            uaddr;
    logic [7:0]            mop;
    logic [P_FLOW_W-1:0]   flow;
    logic [4:0]            op;
    logic                  go;
    logic                  inc_code;
    logic                  end_code;
    logic                  is_jcb;

    assign flow   = iUop[9 +: P_FLOW_W];
    assign op     = iUop[8:4];
    assign is_jcb = (op == P_JCB);
    // A uop only issues in EXEC when the datapath is not stalling.
    assign go     = (state == S_EXEC) && !iStall;

    // Flow codes 5-7 fall through to the plain "op" behaviour.
    always_comb begin
        inc_code = 1'b0;
        end_code = 1'b0;
        case (flow)
            P_FLOW_W'(1): inc_code = 1'b1;
            P_FLOW_W'(2): end_code = 1'b1;
            P_FLOW_W'(3): begin
                inc_code = 1'b1;
                end_code = 1'b1;
            end
            P_FLOW_W'(4): begin
                inc_code = 1'b1;
                end_code = iZeroFlag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state <= S_IDLE;
            uaddr <= 8'h00;
            mop   <= 8'h00;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (iMopValid) begin
                        mop   <= iMemData;
                        state <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    uaddr <= iFlowIdx;
                    state <= S_EXEC;
                end
                S_DISPATCH_CB: begin
                    uaddr <= iCbFlowIdx;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!iStall) begin
                        // A CB jump overrides the flow's own end/advance decision.
                        if (is_jcb) begin
                            mop   <= iMemData;
                            state <= S_DISPATCH_CB;
                        end else if (end_code) begin
                            state <= S_FETCH;
                        end else begin
                            uaddr <= uaddr + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oMop      = mop;
    assign oUAddr    = uaddr;
    assign oUopValid = go;
    assign oUopOp    = op;
    assign oUopArg   = iUop[3:0];
    assign oIncPc    = go && inc_code;
    assign oRetire   = go && end_code && !is_jcb;
    assign oFetchReq = (state == S_FETCH);
    assign oState    = state;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq: ROM and LUTs are modelled as arrays indexed by
// the DUT's address outputs; each scenario checks against hand-computed values.
module tb_dzcpu_useq;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DISP = 3'd2,
                           ST_DISP_CB = 3'd3, ST_EXEC = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mop_valid, zero_flag, stall;
    logic [7:0]  mem_data, flow_idx, cb_flow_idx;
    logic [11:0] uop;
    logic [7:0]  mop, uaddr;
    logic        uop_valid, inc_pc, fetch_req, retire;
    logic [4:0]  uop_op;
    logic [3:0]  uop_arg;
    logic [2:0]  state;

    logic [11:0] rom   [256];
    logic [7:0]  lut   [256];
    logic [7:0]  cblut [256];

    int total = 0;
    int bad   = 0;

    assign uop         = rom[uaddr];
    assign flow_idx    = lut[mop];
    assign cb_flow_idx = cblut[mop];

    always #5 clk = ~clk;

    dzcpu_useq dut (
        .iClock(clk), .iReset(rst_n), .iMopValid(mop_valid), .iMemData(mem_data),
        .iFlowIdx(flow_idx), .iCbFlowIdx(cb_flow_idx), .iUop(uop),
        .iZeroFlag(zero_flag), .iStall(stall), .oMop(mop), .oUAddr(uaddr),
        .oUopValid(uop_valid), .oUopOp(uop_op), .oUopArg(uop_arg), .oIncPc(inc_pc),
        .oFetchReq(fetch_req), .oRetire(retire), .oState(state)
    );

    function automatic logic [11:0] mk_uop(input logic [2:0] f, input logic [4:0] o,
                                           input logic [3:0] a);
        return {f, o, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enter with the DUT in FETCH; leaves it in the first EXEC cycle.
    task automatic do_fetch(input logic [7:0] opc);
        mop_valid = 1'b1;
        mem_data  = opc;
        step();
        mop_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mop_valid = 1'b0; mem_data = 8'h00; zero_flag = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
        total++; if ({uaddr, mop} !== 16'h0000) begin bad++; $display("FAIL reset_regs got=%h exp=0000", {uaddr, mop}); end
        total++; if ({uop_valid, inc_pc, retire, fetch_req} !== 4'b0000) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {uop_valid, inc_pc, retire, fetch_req}); end
        rst_n = 1'b1;
        #1;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL idle_after_release got=%0d exp=%0d", state, ST_IDLE); end
        step();
        total++; if ({state, fetch_req} !== {ST_FETCH, 1'b1}) begin bad++; $display("FAIL idle_to_fetch got=%0d/%b exp=1/1", state, fetch_req); end
    endtask

    task automatic test_basic_flow();
        logic [7:0] exp_addr [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic       exp_inc  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       exp_ret  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        step();
        total++; if ({state, fetch_req} !== {ST_FETCH, 1'b1}) begin bad++; $display("FAIL fetch_hold got=%0d/%b exp=1/1", state, fetch_req); end
        // Stall must not affect the FETCH handshake.
        mop_valid = 1'b1; mem_data = 8'h31; stall = 1'b1;
        step();
        mop_valid = 1'b0; stall = 1'b0;
        #1;
        total++; if ({state, mop} !== {ST_DISP, 8'h31}) begin bad++; $display("FAIL dispatch got=%0d/%h exp=2/31", state, mop); end
        total++; if ({uop_valid, inc_pc, retire} !== 3'b000) begin bad++; $display("FAIL dispatch_strobes got=%b exp=000", {uop_valid, inc_pc, retire}); end
        step();
        total++; if ({uop_op, uop_arg} !== 9'h035) begin bad++; $display("FAIL uop_fields got=%h exp=035", {uop_op, uop_arg}); end
        for (int i = 0; i < 4; i++) begin
            total++; if (uaddr !== exp_addr[i]) begin bad++; $display("FAIL basic_addr%0d got=%0d exp=%0d", i, uaddr, exp_addr[i]); end
            total++; if ({uop_valid, inc_pc, retire} !== {1'b1, exp_inc[i], exp_ret[i]}) begin bad++; $display("FAIL basic_strobes%0d got=%b exp=%b", i, {uop_valid, inc_pc, retire}, {1'b1, exp_inc[i], exp_ret[i]}); end
            step();
        end
        total++; if ({state, uop_valid, fetch_req} !== {ST_FETCH, 1'b0, 1'b1}) begin bad++; $display("FAIL basic_back_to_fetch got=%0d/%b/%b exp=1/0/1", state, uop_valid, fetch_req); end
    endtask

    task automatic test_zero_flag();
        zero_flag = 1'b1;
        do_fetch(8'h40);
        total++; if ({uaddr, inc_pc, retire} !== {8'd19, 2'b11}) begin bad++; $display("FAIL z1_retire got=%0d/%b exp=19/11", uaddr, {inc_pc, retire}); end
        step();
        total++; if (state !== ST_FETCH) begin bad++; $display("FAIL z1_fetch got=%0d exp=1", state); end
        zero_flag = 1'b0;
        do_fetch(8'h40);
        total++; if ({uaddr, inc_pc, retire} !== {8'd19, 2'b10}) begin bad++; $display("FAIL z0_continue got=%0d/%b exp=19/10", uaddr, {inc_pc, retire}); end
        step();
        total++; if ({uaddr, inc_pc, retire} !== {8'd20, 2'b01}) begin bad++; $display("FAIL z0_next got=%0d/%b exp=20/01", uaddr, {inc_pc, retire}); end
        step();
        total++; if (state !== ST_FETCH) begin bad++; $display("FAIL z0_fetch got=%0d exp=1", state); end
    endtask

    task automatic test_jcb();
        do_fetch(8'h50);
        mem_data = 8'h7C;
        #1;
        total++; if ({uaddr, uop_valid, inc_pc, retire} !== {8'd15, 3'b110}) begin bad++; $display("FAIL jcb_exec got=%0d/%b exp=15/110", uaddr, {uop_valid, inc_pc, retire}); end
        step();
        total++; if ({state, mop, uop_valid} !== {ST_DISP_CB, 8'h7C, 1'b0}) begin bad++; $display("FAIL jcb_dispatch got=%0d/%h/%b exp=3/7c/0", state, mop, uop_valid); end
        step();
        total++; if ({state, uaddr, retire} !== {ST_EXEC, 8'd16, 1'b1}) begin bad++; $display("FAIL jcb_cbflow got=%0d/%0d/%b exp=4/16/1", state, uaddr, retire); end
        step();
        total++; if (state !== ST_FETCH) begin bad++; $display("FAIL jcb_fetch got=%0d exp=1", state); end
    endtask

    task automatic test_stall();
        do_fetch(8'h60);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({uaddr, uop_valid, inc_pc, retire} !== {8'd6, 3'b000}) begin bad++; $display("FAIL stall%0d got=%0d/%b exp=6/000", i, uaddr, {uop_valid, inc_pc, retire}); end
            step();
        end
        stall = 1'b0;
        #1;
        total++; if ({uaddr, uop_valid, inc_pc} !== {8'd6, 2'b11}) begin bad++; $display("FAIL stall_release got=%0d/%b exp=6/11", uaddr, {uop_valid, inc_pc}); end
        step();
        total++; if ({uaddr, retire} !== {8'd7, 1'b1}) begin bad++; $display("FAIL stall_resume got=%0d/%b exp=7/1", uaddr, retire); end
        step();
    endtask

    task automatic test_wrap();
        do_fetch(8'h70);
        total++; if ({uaddr, retire} !== {8'hFF, 1'b0}) begin bad++; $display("FAIL wrap_ff got=%h/%b exp=ff/0", uaddr, retire); end
        step();
        total++; if ({uaddr, retire} !== {8'h00, 1'b1}) begin bad++; $display("FAIL wrap_00 got=%h/%b exp=00/1", uaddr, retire); end
        step();
    endtask

    task automatic test_reset_mid_flow();
        do_fetch(8'h31);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({state, uaddr, mop} !== {ST_IDLE, 16'h0000}) begin bad++; $display("FAIL async_reset got=%0d/%h/%h exp=0/00/00", state, uaddr, mop); end
        total++; if ({uop_valid, inc_pc, retire, fetch_req} !== 4'b0000) begin bad++; $display("FAIL async_strobes got=%b exp=0000", {uop_valid, inc_pc, retire, fetch_req}); end
        step();
        rst_n = 1'b1;
        #1;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL restart_idle got=%0d exp=0", state); end
        step();
        total++; if ({state, fetch_req} !== {ST_FETCH, 1'b1}) begin bad++; $display("FAIL restart_fetch got=%0d/%b exp=1/1", state, fetch_req); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 12'h000; lut[i] = 8'h00; cblut[i] = 8'h00;
        end
        lut[8'h31] = 8'd1;
        rom[1]  = mk_uop(3'd1, 5'h03, 4'h5);
        rom[2]  = mk_uop(3'd1, 5'h04, 4'h1);
        rom[3]  = mk_uop(3'd0, 5'h05, 4'h2);
        rom[4]  = mk_uop(3'd3, 5'h06, 4'h3);
        lut[8'h40] = 8'd19;
        rom[19] = mk_uop(3'd4, 5'h07, 4'h0);
        rom[20] = mk_uop(3'd2, 5'h08, 4'h0);
        lut[8'h50] = 8'd15;
        rom[15] = mk_uop(3'd3, 5'h0A, 4'h0);
        cblut[8'h7C] = 8'd16;
        rom[16] = mk_uop(3'd2, 5'h09, 4'h4);
        lut[8'h60] = 8'd5;
        rom[5]  = mk_uop(3'd0, 5'h01, 4'h0);
        rom[6]  = mk_uop(3'd1, 5'h02, 4'h0);
        rom[7]  = mk_uop(3'd2, 5'h03, 4'h0);
        lut[8'h70] = 8'hFF;
        rom[255] = mk_uop(3'd0, 5'h0B, 4'h0);
        rom[0]   = mk_uop(3'd2, 5'h0C, 4'h0);

        test_reset();
        test_basic_flow();
        test_zero_flag();
        test_jcb();
        test_stall();
        test_wrap();
        test_reset_mid_flow();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
